// File: rtl/rollo_ct_readout_pkg.sv
// rollo_ct_readout_pkg
//   Shared constants and state encoding for the ROLLO-I ciphertext readout
//   block. Default widths match the encryption core's result memory.
package rollo_ct_readout_pkg;

  localparam int PKG_DW         = 32;
  localparam int PKG_CT_WORDS   = 48;
  localparam int PKG_FIFO_DEPTH = 4;
  localparam int PKG_AW         = $clog2(PKG_CT_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/rollo_ct_readout_if.sv
// rollo_ct_readout_if
//   Bus bundle of the readout block: the 1-cycle-latency read port into the
//   core's result memory and the valid/ready word stream to the host.
//   master : the readout block (drives read strobe/address and stream data)
//   slave  : the environment (memory returning enc_data, host driving out_ready)
interface rollo_ct_readout_if #(
  parameter int DW = 32,
  parameter int AW = 6
) ();

  logic          enc_rd_en;
  logic [AW-1:0] enc_addr;
  logic [DW-1:0] enc_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output enc_rd_en, enc_addr, out_data, out_valid,
    input  enc_data, out_ready
  );

  modport slave (
    input  enc_rd_en, enc_addr, out_data, out_valid,
    output enc_data, out_ready
  );

endinterface

// File: rtl/rollo_sync_fifo.sv
// rollo_sync_fifo
//   Small synchronous FIFO with a combinational head (dout_o = oldest word).
//   DEPTH must be a power of 2 so the pointers wrap naturally.
//   Ports: clk_i, rst_b_i (sync, active-low), push_i/din_i, pop_i,
//          dout_o (head), count_o, full_o, empty_o.
module rollo_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_b_i,
  input  logic                     push_i,
  input  logic [DW-1:0]            din_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers/count define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/rollo_ct_readout.sv
// rollo_ct_readout
//   After the ROLLO-I core raises enc_ready, fetches CT_WORDS ciphertext words
//   from the core's result memory (1-cycle read latency), buffers them in a
//   FIFO_DEPTH-word FIFO and streams them to the host over valid/ready, keeping
//   a running XOR checksum of accepted words.
//   Ports: clk, rst_b (sync, active-low), enc_ready (start level, rising edge
//          starts a readout), bus (read port + output stream, master side),
//          busy, done (1-cycle pulse), checksum.
module rollo_ct_readout
  import rollo_ct_readout_pkg::*;
#(
  parameter int DW         = PKG_DW,
  parameter int CT_WORDS   = PKG_CT_WORDS,
  parameter int FIFO_DEPTH = PKG_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 enc_ready,
  rollo_ct_readout_if.master   bus,
  output logic                 busy,
  output logic                 done,
  output logic [DW-1:0]        checksum
);

  localparam int AW = (CT_WORDS > 1) ? $clog2(CT_WORDS) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state_q;
  logic          prev_ready_q;
  logic          rd_en_q;
  logic          inflight_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] addr_q;
  logic [AW:0]   issued_q;
  logic [AW:0]   accepted_q;
  logic [DW-1:0] checksum_q;

  logic [DW-1:0] fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          start;
  logic [CW:0]   occ_nx;
  logic          credit_ok;

  assign pop   = !fifo_empty && bus.out_ready;
  assign start = enc_ready && !prev_ready_q;

  // The strobe is registered, so the credit decision looks one cycle ahead:
  // next-cycle FIFO count plus the read that will then be in flight.
  assign occ_nx = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop)
                + (CW+1)'(rd_en_q);
  assign credit_ok = (occ_nx < (CW+1)'(FIFO_DEPTH))
                  && (issued_q < (AW+1)'(CT_WORDS))
                  && !(fifo_full && !pop);

  rollo_sync_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_b_i (rst_b),
    .push_i  (inflight_q),
    .din_i   (bus.enc_data),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.enc_rd_en = rd_en_q;
  assign bus.enc_addr  = addr_q;
  assign bus.out_data  = fifo_dout;
  assign bus.out_valid = !fifo_empty;
  assign busy          = busy_q;
  assign done          = done_q;
  assign checksum      = checksum_q;

  // issued_q counts strobes up to and including the one currently on the port.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q      <= S_IDLE;
      prev_ready_q <= 1'b0;
      rd_en_q      <= 1'b0;
      inflight_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      addr_q       <= '0;
      issued_q     <= '0;
      accepted_q   <= '0;
      checksum_q   <= '0;
    end else begin
      prev_ready_q <= enc_ready;
      inflight_q   <= rd_en_q;
      done_q       <= 1'b0;
      if (pop) begin
        checksum_q <= checksum_q ^ fifo_dout;
        accepted_q <= accepted_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_FETCH;
            busy_q     <= 1'b1;
            rd_en_q    <= 1'b1;
            addr_q     <= '0;
            issued_q   <= (AW+1)'(1);
            accepted_q <= '0;
            checksum_q <= '0;
          end
        end
        S_FETCH: begin
          if (issued_q == (AW+1)'(CT_WORDS)) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
          end else if (credit_ok) begin
            rd_en_q  <= 1'b1;
            addr_q   <= issued_q[AW-1:0];
            issued_q <= issued_q + 1'b1;
          end else begin
            rd_en_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (accepted_q == (AW+1)'(CT_WORDS)) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rollo_ct_readout.sv
module tb_rollo_ct_readout;

  localparam int DW = 32;
  localparam int CT = 48;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          enc_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  rollo_ct_readout_if #(.DW(DW), .AW(AW)) bus ();

  rollo_ct_readout #(.DW(DW), .CT_WORDS(CT), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .enc_ready (enc_ready),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  // Result memory of the core: 1-cycle read latency.
  logic [DW-1:0] mem   [64];
  logic [DW-1:0] exp_w [CT];
  always @(posedge clk) if (bus.enc_rd_en) bus.enc_data <= mem[bus.enc_addr];

  int checks = 0;
  int errors = 0;

  // Model state: what has happened so far in the current readout.
  bit          model_on = 1'b0;
  int          issued, acc, iss_lag, done_cnt, cyc_cnt, first_acc, last_acc;
  int          stall_rd;
  logic [31:0] model_ck, first_d, last_d, prev_data;
  bit          prev_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  task automatic model_reset();
    issued = 0; acc = 0; iss_lag = 0; done_cnt = 0;
    model_ck = '0; prev_stall = 1'b0; prev_data = '0;
    first_acc = -1; last_acc = -1; first_d = '0; last_d = '0;
  endtask

  task automatic load_mem(input logic [31:0] base);
    for (int i = 0; i < CT; i++) begin
      mem[i]   = base + 32'(i);
      exp_w[i] = base + 32'(i);
    end
  endtask

  // Per-cycle comparison against the abstract readout model:
  //  - outstanding words (issued - accepted) never exceed 4, and a read is
  //    issued whenever credit allows and words remain
  //  - a word is visible 2 cycles after its strobe; stream = memory in order
  //  - checksum = XOR of words accepted so far
  always @(negedge clk) begin
    bit exp_rd;
    bit exp_v;
    cyc_cnt++;
    if (model_on) begin
      exp_rd = busy && (issued < CT) && ((issued - acc) < 4);
      chk("rd_en", 32'(bus.enc_rd_en), 32'(exp_rd));
      if (bus.enc_rd_en) chk("addr", 32'(bus.enc_addr), 32'(issued));
      exp_v = (iss_lag > acc);
      chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
      if (bus.out_valid && acc < CT) chk("out_data", bus.out_data, exp_w[acc]);
      if (prev_stall) chk("hold", bus.out_data, prev_data);
      if (busy || done) chk("checksum", checksum, model_ck);
      if (done) begin
        chk("done_all_accepted", 32'(acc), 32'(CT));
        chk("done_busy_low", 32'(busy), 32'd0);
        done_cnt++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      iss_lag    = issued;
      if (bus.enc_rd_en) issued++;
      if (bus.out_valid && bus.out_ready) begin
        model_ck = model_ck ^ bus.out_data;
        if (acc == 0) begin
          first_d   = bus.out_data;
          first_acc = cyc_cnt;
        end
        last_d   = bus.out_data;
        last_acc = cyc_cnt;
        acc++;
      end
    end
  end

  // Drop enc_ready for one cycle, load memory, raise it again.
  task automatic start_run(input logic [31:0] base);
    enc_ready = 1'b0;
    @(posedge clk); #1;
    load_mem(base);
    model_reset();
    model_on  = 1'b1;
    enc_ready = 1'b1;
  endtask

  // mode 0: ready=1; 1: ready pattern 1,0,0,1; 2: ready=0 for 20 cycles;
  // 3: ready=1 with a second enc_ready rise at word 10.
  task automatic run(input int mode, input int stop_at, output int first_v);
    int  spur;
    bit  timed_out;
    spur = 0; first_v = -1; timed_out = 1'b1; stall_rd = 0;
    for (int c = 0; c < 3000; c++) begin
      case (mode)
        1:       bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
        2:       bus.out_ready = (c >= 20);
        default: bus.out_ready = 1'b1;
      endcase
      if (mode == 3) begin
        if (spur == 0 && acc >= 10) begin
          enc_ready = 1'b0; spur = 1;
        end else if (spur == 1) begin
          enc_ready = 1'b1; spur = 2;
        end
      end
      @(posedge clk); #1;
      if (first_v < 0 && bus.out_valid) first_v = c + 1;
      if (mode == 2 && c + 1 <= 19) begin
        if (bus.enc_rd_en) stall_rd++;
        if (c + 1 >= 3) begin
          chk("stall_valid", 32'(bus.out_valid), 32'd1);
          chk("stall_data", bus.out_data, 32'hA5A50000);
        end
      end
      if (done || acc >= stop_at) begin
        timed_out = 1'b0;
        break;
      end
    end
    if (timed_out) begin
      checks++;
      errors++;
      $display("FAIL run_timeout mode=%0d accepted=%0d", mode, acc);
    end
  endtask

  task automatic finish_checks(input string nm, input logic [31:0] ck);
    @(negedge clk); #1;
    chk({nm, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({nm, "_accepted"}, 32'(acc), 32'(CT));
    chk({nm, "_checksum"}, checksum, ck);
  endtask

  initial begin
    int fv;
    bus.out_ready = 1'b1;
    // Reset with enc_ready already high: the level must count as a rising edge.
    enc_ready = 1'b1;
    load_mem(32'hA5A50000);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(bus.enc_rd_en), 32'd0);
    chk("rst_addr", 32'(bus.enc_addr), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    rst_b    = 1'b1;
    model_on = 1'b1;

    // Basic streaming
    run(0, 1000, fv);
    chk("basic_latency", 32'(fv), 32'd3);
    chk("basic_throughput", 32'(last_acc - first_acc), 32'd47);
    chk("basic_first", first_d, 32'hA5A50000);
    chk("basic_last", last_d, 32'hA5A5002F);
    finish_checks("basic", 32'h00000000);

    // Backpressure
    start_run(32'hA5A50000);
    run(1, 1000, fv);
    finish_checks("bp", 32'h00000000);

    // Full stall
    start_run(32'hA5A50000);
    run(2, 1000, fv);
    chk("stall_reads", 32'(stall_rd), 32'd4);
    finish_checks("stall", 32'h00000000);

    // Spurious start
    start_run(32'hA5A50000);
    run(3, 1000, fv);
    finish_checks("spur", 32'h00000000);
    repeat (10) @(posedge clk);
    #1;
    chk("spur_no_restart", 32'(busy), 32'd0);
    chk("spur_single_done", 32'(done_cnt), 32'd1);

    // Reset mid-operation after 21 words (XOR 0..20 = 0x14, odd word count)
    start_run(32'hA5A50000);
    run(0, 21, fv);
    chk("pre_rst_checksum", checksum, 32'hA5A50014);
    model_on  = 1'b0;
    rst_b     = 1'b0;
    enc_ready = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_checksum", checksum, 32'd0);
    chk("mid_rst_rd_en", 32'(bus.enc_rd_en), 32'd0);
    rst_b = 1'b1;
    start_run(32'hA5A50000);
    run(0, 1000, fv);
    chk("restart_first", first_d, 32'hA5A50000);
    finish_checks("restart", 32'h00000000);

    // Back-to-back: words 0x3C3C0001..0x3C3C0030, XOR = 0x30
    start_run(32'h3C3C0001);
    run(0, 1000, fv);
    chk("b2b_first", first_d, 32'h3C3C0001);
    chk("b2b_last", last_d, 32'h3C3C0030);
    finish_checks("b2b", 32'h00000030);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/rollo_ct_readout.md
Name: rollo_ct_readout

Overview:
- Downstream of the ROLLO-I encryption core: once the core asserts ready, this block fetches the ciphertext words from the core's result memory.
- Fetches use a 1-cycle-latency read port and are buffered in a small FIFO.
- Words stream to the host over a valid/ready interface; a running XOR checksum is kept for bring-up and bench comparison.

Parameters:
- DW, 32, data word width (matches the core's data bus).
- CT_WORDS, 48, number of ciphertext words per encryption.
- FIFO_DEPTH, 4, output buffer depth in words (power of 2, at least 2).
- AW, clog2(CT_WORDS), read address width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_b  input  1  synchronous active-low reset.
- enc_ready  input  1  core completion flag (level; a rising edge starts readout).
- enc_rd_en  output  1  read strobe to core result memory.
- enc_addr  output  AW  word address to core result memory.
- enc_data  input  DW  read data, valid exactly 1 cycle after enc_rd_en.
- out_data  output  DW  head of FIFO.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  host accepts out_data when out_valid && out_ready.
- busy  output  1  readout in progress.
- done  output  1  single-cycle pulse after last word is accepted by host.
- checksum  output  DW  XOR of all words accepted by host in the current readout.

Behaviour:
- Reset (rst_b=0 at a clock edge), regardless of state:
  - state=IDLE; all outputs 0 (enc_rd_en, enc_addr, out_valid, busy, done, checksum).
  - FIFO emptied; in-flight read discarded.
  - enc_ready edge detector register cleared to 0, so a level-high enc_ready after reset counts as a rising edge.
- States: IDLE, FETCH, DRAIN, FIN.
- IDLE:
  - On enc_ready 0->1 (registered previous value): clear checksum, issue address and fetch counters, and go to FETCH.
  - busy=1 from the next cycle.
- FETCH:
  - enc_rd_en=1 in a cycle iff (fifo_count + inflight) < FIFO_DEPTH and issued < CT_WORDS.
  - enc_addr = issued count, 0..CT_WORDS-1 in order.
  - inflight=1 in the cycle after a strobe; enc_data is written to the FIFO in that cycle.
  - When the last address has been issued, go to DRAIN.
- DRAIN: when accepted == CT_WORDS, go to FIN.
- FIN: done=1 for exactly one cycle; busy=0; return to IDLE.
- FIFO:
  - Simultaneous push and pop in one cycle is legal; count is unchanged and data order is preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - Never overflows: the credit rule above guarantees it.
  - out_data is stable while out_valid && !out_ready.
- Checksum: checksum ^= out_data on each accepted transfer.
- Throughput: with out_ready held at 1, one word per cycle; first out_valid 3 cycles after the enc_ready edge.
- enc_ready edges seen while busy are ignored (no restart, no queuing).
- enc_ready falling during readout has no effect.
- The host may stall indefinitely; the block waits in FETCH or DRAIN.
- Counters are AW+1 bits wide so CT_WORDS = 2^AW is handled.

Decomposition:
- Shared package/header (alongside define.v): DW, CT_WORDS per parameter set, and the state encodings.
- clog2.v supplies AW.
- One natural sub-module, rollo_sync_fifo (DW, FIFO_DEPTH), providing count, full and empty.
- FSM, credit logic and checksum live in the top.

Test Plan:
- Basic streaming:
  - Stimulus: memory model word[i]=32'hA5A50000+i; out_ready=1; one enc_ready edge.
  - Required: 48 words in order 0xA5A50000..0xA5A5002F, one per cycle after a 3-cycle latency; done pulses once; checksum = XOR of all 48 words.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 repeating.
  - Required: no loss or duplication; enc_rd_en deasserts when FIFO plus in-flight reaches 4; out_data is held during stalls.
- Full stall:
  - Stimulus: out_ready=0 for 20 cycles after start, then 1.
  - Required: exactly 4 reads issued (addr 0..3); out_valid=1 and out_data=word[0] throughout the stall; all 48 words then complete.
- Spurious start:
  - Stimulus: a second enc_ready rise at word 10.
  - Required: ignored; exactly 48 words; a single done pulse.
- Reset mid-operation:
  - Stimulus: rst_b=0 for 1 cycle at word 20.
  - Required: next cycle out_valid=0, busy=0, checksum=0; a fresh enc_ready edge restarts from addr 0.
- Back-to-back runs:
  - Stimulus: enc_ready falls then rises again 1 cycle after done, with different memory contents.
  - Required: the second readout is correct and checksum restarts from 0.
